// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: combinational stall/flush generation for the
// IF/ID/EX registers, TPU serialization FSM with watchdog, and a stall-cycle counter.
module hazard_ctrl #(
  parameter logic [1:0] LOAD_WB_SEL = 2'b01,
  parameter int         TPU_TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  d_op1_reg_i,
  input  logic [4:0]  d_op2_reg_i,
  input  logic        d_tpu_op_i,
  input  logic        ex_reg_write_enable_i,
  input  logic [4:0]  ex_reg_write_dst_i,
  input  logic [1:0]  ex_wb_sel_i,
  input  logic        ex_branch_taken_i,
  input  logic        ex_tpu_start_i,
  input  logic        tpu_done_i,
  input  logic        mem_cache_valid_i,
  input  logic        mem_ready_i,
  output logic        pc_stall_o,
  output logic        fd_stall_o,
  output logic        de_stall_o,
  output logic        em_stall_o,
  output logic        fd_flush_o,
  output logic        de_flush_o,
  output logic        tpu_busy_o,
  output logic        tpu_timeout_o,
  output logic [31:0] stall_cycles_o
);

  localparam int CW = $clog2(TPU_TIMEOUT);
  localparam logic [CW-1:0] TPU_TERM = CW'(TPU_TIMEOUT - 1);

  typedef enum logic {IDLE, TPU_BUSY} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] tpu_cnt_q, tpu_cnt_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;

  logic memwait, loaduse, tpuhaz;

  assign memwait = mem_cache_valid_i && !mem_ready_i;
  assign loaduse = ex_reg_write_enable_i && (ex_wb_sel_i == LOAD_WB_SEL) &&
                   (ex_reg_write_dst_i != 5'd0) &&
                   ((ex_reg_write_dst_i == d_op1_reg_i) || (ex_reg_write_dst_i == d_op2_reg_i));
  assign tpuhaz  = d_tpu_op_i && ((state_q == TPU_BUSY) || ex_tpu_start_i);

  // A cache miss freezes everything, including a taken branch, which re-presents afterwards.
  always_comb begin
    pc_stall_o = 1'b0;
    fd_stall_o = 1'b0;
    de_stall_o = 1'b0;
    em_stall_o = 1'b0;
    fd_flush_o = 1'b0;
    de_flush_o = 1'b0;
    if (memwait) begin
      pc_stall_o = 1'b1;
      fd_stall_o = 1'b1;
      de_stall_o = 1'b1;
      em_stall_o = 1'b1;
    end else if (ex_branch_taken_i) begin
      fd_flush_o = 1'b1;
      de_flush_o = 1'b1;
    end else if (tpuhaz || loaduse) begin
      pc_stall_o = 1'b1;
      fd_stall_o = 1'b1;
      de_flush_o = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    tpu_cnt_d = tpu_cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_tpu_start_i && !memwait) begin
          state_d   = TPU_BUSY;
          tpu_cnt_d = '0;
        end
      end
      TPU_BUSY: begin
        tpu_cnt_d = tpu_cnt_q + CW'(1);
        // Done on the terminal-count cycle wins over the watchdog.
        if (tpu_done_i) begin
          state_d = IDLE;
        end else if (tpu_cnt_q == TPU_TERM) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_cnt_d = (pc_stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) ?
                       stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      tpu_cnt_q   <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      tpu_cnt_q   <= tpu_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign tpu_busy_o     = (state_q == TPU_BUSY);
  assign tpu_timeout_o  = timeout_q;
  assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one default instance plus a TPU_TIMEOUT=8
// instance sharing the same stimulus for the watchdog scenarios.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  d_op1, d_op2;
  logic        d_tpu_op;
  logic        ex_wren;
  logic [4:0]  ex_dst;
  logic [1:0]  ex_wb;
  logic        ex_br;
  logic        ex_start;
  logic        tpu_done;
  logic        mem_valid, mem_ready;

  logic        pc_stall, fd_stall, de_stall, em_stall, fd_flush, de_flush;
  logic        busy, tmo;
  logic [31:0] stall_cnt;

  logic        w_pc_stall, w_fd_stall, w_de_stall, w_em_stall, w_fd_flush, w_de_flush;
  logic        w_busy, w_tmo;
  logic [31:0] w_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [5:0] C_NONE   = 6'b000000;
  localparam logic [5:0] C_FREEZE = 6'b111100;
  localparam logic [5:0] C_BRANCH = 6'b000011;
  localparam logic [5:0] C_BUBBLE = 6'b110001;

  logic [5:0] ctl;
  assign ctl = {pc_stall, fd_stall, de_stall, em_stall, fd_flush, de_flush};

  hazard_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .d_op1_reg_i(d_op1), .d_op2_reg_i(d_op2), .d_tpu_op_i(d_tpu_op),
    .ex_reg_write_enable_i(ex_wren), .ex_reg_write_dst_i(ex_dst), .ex_wb_sel_i(ex_wb),
    .ex_branch_taken_i(ex_br), .ex_tpu_start_i(ex_start), .tpu_done_i(tpu_done),
    .mem_cache_valid_i(mem_valid), .mem_ready_i(mem_ready),
    .pc_stall_o(pc_stall), .fd_stall_o(fd_stall), .de_stall_o(de_stall), .em_stall_o(em_stall),
    .fd_flush_o(fd_flush), .de_flush_o(de_flush),
    .tpu_busy_o(busy), .tpu_timeout_o(tmo), .stall_cycles_o(stall_cnt)
  );

  hazard_ctrl #(.TPU_TIMEOUT(8)) dut_wd (
    .clk_i(clk), .rst_i(rst),
    .d_op1_reg_i(d_op1), .d_op2_reg_i(d_op2), .d_tpu_op_i(d_tpu_op),
    .ex_reg_write_enable_i(ex_wren), .ex_reg_write_dst_i(ex_dst), .ex_wb_sel_i(ex_wb),
    .ex_branch_taken_i(ex_br), .ex_tpu_start_i(ex_start), .tpu_done_i(tpu_done),
    .mem_cache_valid_i(mem_valid), .mem_ready_i(mem_ready),
    .pc_stall_o(w_pc_stall), .fd_stall_o(w_fd_stall), .de_stall_o(w_de_stall), .em_stall_o(w_em_stall),
    .fd_flush_o(w_fd_flush), .de_flush_o(w_de_flush),
    .tpu_busy_o(w_busy), .tpu_timeout_o(w_tmo), .stall_cycles_o(w_stall_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  // Driver tasks
  task automatic idle_inputs();
    d_op1 = 5'd0; d_op2 = 5'd0; d_tpu_op = 1'b0;
    ex_wren = 1'b0; ex_dst = 5'd0; ex_wb = 2'b00;
    ex_br = 1'b0; ex_start = 1'b0; tpu_done = 1'b0;
    mem_valid = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
    check_eq("reset_ctl", 32'(ctl), 32'(C_NONE));
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_tmo", 32'(tmo), 32'd0);
    check_eq("reset_stall_cnt", stall_cnt, 32'd0);

    // Load-use on op2
    tick();
    ex_wren = 1'b1; ex_wb = 2'b01; ex_dst = 5'd5; d_op2 = 5'd5;
    settle();
    check_eq("loaduse_op2", 32'(ctl), 32'(C_BUBBLE));
    tick();
    idle_inputs();
    settle();
    check_eq("loaduse_release", 32'(ctl), 32'(C_NONE));
    check_eq("loaduse_cnt", stall_cnt, 32'd1);

    // dst=0 never hazards; non-load never hazards
    ex_wren = 1'b1; ex_wb = 2'b01; ex_dst = 5'd0; d_op1 = 5'd0;
    settle();
    check_eq("loaduse_r0", 32'(ctl), 32'(C_NONE));
    ex_wb = 2'b10; ex_dst = 5'd7; d_op1 = 5'd7;
    settle();
    check_eq("alu_no_hazard", 32'(ctl), 32'(C_NONE));
    ex_wb = 2'b01;
    settle();
    check_eq("loaduse_op1", 32'(ctl), 32'(C_BUBBLE));
    tick();

    // Branch beats load-use
    ex_br = 1'b1;
    settle();
    check_eq("branch_over_loaduse", 32'(ctl), 32'(C_BRANCH));
    tick();

    // Cache miss freezes a pending branch for 3 cycles
    idle_inputs();
    ex_br = 1'b1; mem_valid = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq($sformatf("freeze_%0d", i), 32'(ctl), 32'(C_FREEZE));
      tick();
    end
    mem_ready = 1'b1;
    settle();
    check_eq("freeze_release_branch", 32'(ctl), 32'(C_BRANCH));
    check_eq("freeze_cnt", stall_cnt, 32'd5);
    tick();

    // TPU serialization: start with a dependent TPU op behind it
    idle_inputs();
    ex_start = 1'b1; d_tpu_op = 1'b1;
    settle();
    check_eq("tpu_c0_ctl", 32'(ctl), 32'(C_BUBBLE));
    check_eq("tpu_c0_busy", 32'(busy), 32'd0);
    tick();
    ex_start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tpu_done = (c == 10);
      settle();
      check_eq($sformatf("tpu_c%0d_busy", c), 32'(busy), 32'd1);
      check_eq($sformatf("tpu_c%0d_ctl", c), 32'(ctl), 32'(C_BUBBLE));
      tick();
    end
    tpu_done = 1'b0;
    settle();
    check_eq("tpu_c11_busy", 32'(busy), 32'd0);
    check_eq("tpu_c11_ctl", 32'(ctl), 32'(C_NONE));
    check_eq("tpu_stall_cnt", stall_cnt, 32'd16);
    tick();

    // Watchdog (TPU_TIMEOUT=8): busy exactly 8 cycles then a one-cycle pulse
    idle_inputs();
    ex_start = 1'b1;
    tick();
    ex_start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      settle();
      check_eq($sformatf("wd_c%0d_busy", c), 32'(w_busy), 32'd1);
      check_eq($sformatf("wd_c%0d_tmo", c), 32'(w_tmo), 32'd0);
      tick();
    end
    settle();
    check_eq("wd_c9_busy", 32'(w_busy), 32'd0);
    check_eq("wd_c9_tmo", 32'(w_tmo), 32'd1);
    tick();
    settle();
    check_eq("wd_c10_tmo", 32'(w_tmo), 32'd0);
    check_eq("main_still_busy", 32'(busy), 32'd1);
    tick();

    // Watchdog with done on the 8th busy cycle: no pulse
    ex_start = 1'b1;
    tick();
    ex_start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tpu_done = (c == 8);
      settle();
      check_eq($sformatf("wd2_c%0d_busy", c), 32'(w_busy), 32'd1);
      tick();
    end
    tpu_done = 1'b0;
    settle();
    check_eq("wd2_c9_busy", 32'(w_busy), 32'd0);
    check_eq("wd2_c9_tmo", 32'(w_tmo), 32'd0);
    check_eq("main_done_idle", 32'(busy), 32'd0);
    tick();
    settle();
    check_eq("wd2_c10_tmo", 32'(w_tmo), 32'd0);

    // Reset mid-op with stall count at 20
    ex_start = 1'b1; d_tpu_op = 1'b1;
    tick();
    ex_start = 1'b0;
    tick();
    tick();
    tick();
    d_tpu_op = 1'b0;
    settle();
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    check_eq("pre_rst_cnt", stall_cnt, 32'd20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_cnt", stall_cnt, 32'd0);
    check_eq("rst_tmo", 32'(tmo), 32'd0);
    tpu_done = 1'b1;
    tick();
    tpu_done = 1'b0;
    settle();
    check_eq("late_done_busy", 32'(busy), 32'd0);

    // A start during a cache freeze is not taken
    ex_start = 1'b1; mem_valid = 1'b1; mem_ready = 1'b0;
    settle();
    check_eq("frozen_start_ctl", 32'(ctl), 32'(C_FREEZE));
    tick();
    idle_inputs();
    settle();
    check_eq("frozen_start_busy", 32'(busy), 32'd0);
    check_eq("frozen_start_cnt", stall_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
